pid_speed_ctrl: RTL

Closed-loop speed controller sitting directly downstream of the encoder RPM reader. It consumes each signed RPM sample on its valid strobe and computes a PID correction against a signed setpoint, using one shared multiplier sequenced by a small FSM. It emits a saturated PWM duty magnitude plus a direction bit for the motor PWM/H-bridge stage.

---
 rtl/pid_pkg.sv | 28 ++
 rtl/pid_speed_ctrl_sat_clamp.sv | 20 ++
 rtl/pid_speed_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared types, widths and helpers for the PID speed controller.
// Holds the FSM state enum, datapath widths and a signed clamp.
package pid_pkg;

  localparam int FRAC_BITS = 8;
  localparam int E_W       = 17;
  localparam int ACC_W     = 24;
  localparam int PROD_W    = 42;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    SUM,
    OUT
  } state_t;

  function automatic logic signed [PROD_W-1:0] clamp_s(
    input logic signed [PROD_W-1:0] v,
    input logic signed [PROD_W-1:0] lim
  );
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pid_speed_ctrl_sat_clamp.sv
// Parameterised signed saturate to +/-LIM.
// Ports: i_val signed input, o_sat clamped and resized output.
module sat_clamp
  import pid_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 24,
  parameter logic signed [OUT_W-1:0] LIM =
    {1'b0, {(OUT_W-1){1'b1}}}
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_sat
);

  logic signed [PROD_W-1:0] w_c;

  assign w_c   = clamp_s(PROD_W'(i_val), PROD_W'(LIM));
  assign o_sat = OUT_W'(w_c);

endmodule

// File: rtl/pid_speed_ctrl.sv
// PID speed loop: one shared multiplier sequenced over P/I/D terms.
// Ports: clk/rstn, enable_i, setpoint_i, rpm_valid_i/rpm_data_i in; busy_o, overrun_o, duty_valid_o, duty_o, dir_o out.
module pid_speed_ctrl
  import pid_pkg::*;
#(
  parameter int                 DATA_WIDTH = 16,
  parameter logic signed [15:0] KP         = 16'sd256,
  parameter logic signed [15:0] KI         = 16'sd16,
  parameter logic signed [15:0] KD         = 16'sd0,
  parameter logic signed [23:0] INT_LIMIT  = 24'sd65535,
  parameter logic [9:0]         OUT_MAX    = 10'd1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] setpoint_i,
  input  logic                  rpm_valid_i,
  input  logic [DATA_WIDTH-1:0] rpm_data_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  duty_valid_o,
  output logic [9:0]            duty_o,
  output logic                  dir_o
);

  localparam int U_W = PROD_W - FRAC_BITS;
  localparam int M_W = ACC_W + 16;

  state_t r_state, w_state_nx;

  logic signed [E_W-1:0]    r_e, r_e_prev;
  logic signed [E_W:0]      r_d;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_first;
  logic signed [PROD_W-1:0] r_sum;
  logic signed [U_W-1:0]    r_u;

  logic signed [E_W-1:0]    w_e;
  logic signed [E_W:0]      w_d;
  logic signed [ACC_W:0]    w_acc_sum;
  logic signed [ACC_W-1:0]  w_acc_sat;
  logic signed [15:0]       w_ma;
  logic signed [ACC_W-1:0]  w_mb;
  logic signed [M_W-1:0]    w_prod;
  logic signed [10:0]       w_u_sat;
  logic signed [10:0]       w_mag;

  assign w_e = E_W'($signed(setpoint_i))
             - E_W'($signed(rpm_data_i));
  assign w_d = r_first ? '0
             : (E_W+1)'(w_e) - (E_W+1)'(r_e_prev);
  assign w_acc_sum = (ACC_W+1)'(r_acc)
                   + (ACC_W+1)'(w_e);

  sat_clamp #(
    .IN_W (ACC_W+1),
    .OUT_W(ACC_W),
    .LIM  (INT_LIMIT)
  ) u_acc_clamp (
    .i_val(w_acc_sum),
    .o_sat(w_acc_sat)
  );

  sat_clamp #(
    .IN_W (U_W),
    .OUT_W(11),
    .LIM  ($signed({1'b0, OUT_MAX}))
  ) u_out_clamp (
    .i_val(r_u),
    .o_sat(w_u_sat)
  );

  assign w_mag = w_u_sat[10] ? -w_u_sat : w_u_sat;

  always_comb begin
    w_ma = '0;
    w_mb = '0;
    unique case (1'b1)
      (r_state == MUL_P): begin
        w_ma = KP;
        w_mb = ACC_W'(r_e);
      end
      (r_state == MUL_I): begin
        w_ma = KI;
        w_mb = r_acc;
      end
      (r_state == MUL_D): begin
        w_ma = KD;
        w_mb = ACC_W'(r_d);
      end
      default: ;
    endcase
  end

  assign w_prod = w_ma * w_mb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (!enable_i) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (rpm_valid_i) w_state_nx = MUL_P;
        MUL_P:   w_state_nx = MUL_I;
        MUL_I:   w_state_nx = MUL_D;
        MUL_D:   w_state_nx = SUM;
        SUM:     w_state_nx = OUT;
        OUT:     w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign busy_o = (r_state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_e          <= '0;
      r_e_prev     <= '0;
      r_d          <= '0;
      r_acc        <= '0;
      r_first      <= 1'b1;
      r_sum        <= '0;
      r_u          <= '0;
      overrun_o    <= 1'b0;
      duty_valid_o <= 1'b0;
      duty_o       <= '0;
      dir_o        <= 1'b0;
    end else if (!enable_i) begin
      r_e_prev     <= '0;
      r_acc        <= '0;
      r_first      <= 1'b1;
      overrun_o    <= 1'b0;
      duty_valid_o <= 1'b0;
      duty_o       <= '0;
      dir_o        <= 1'b0;
    end else begin
      duty_valid_o <= 1'b0;
      overrun_o    <= rpm_valid_i && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (rpm_valid_i) begin
            r_e   <= w_e;
            r_d   <= w_d;
            r_acc <= w_acc_sat;
          end
        end
        MUL_P: r_sum <= PROD_W'(w_prod);
        MUL_I: r_sum <= r_sum + PROD_W'(w_prod);
        MUL_D: r_sum <= r_sum + PROD_W'(w_prod);
        SUM:   r_u   <= U_W'(r_sum >>> FRAC_BITS);
        OUT: begin
          duty_o       <= 10'(w_mag);
          dir_o        <= w_u_sat[10];
          r_e_prev     <= r_e;
          r_first      <= 1'b0;
          duty_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
